// File: rtl/multi_channel_accumulator.sv
// multi_channel_accumulator
//
// Sums CHANNELS unsigned words per accepted input beat and either forwards
// the beat sum (pass mode) or adds it into a running total (accumulate mode).
// Also counts applied beats and keeps a sticky overflow flag.
//
// Two-stage pipeline:
//   S1  registers the combinational channel sum plus the beat's mode/clear.
//   S2  is the output register: applies mode/clear, updates acc, count and
//       overflow, and presents the result on out_sum.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. The producer holds valid and payload until it sees
// ready. in_ready depends combinationally on out_ready so that a stalled
// pipeline refills on the same cycle the consumer accepts.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        input beat present
//   in_ready        block can accept a beat (0 while rst=1)
//   in_data         CHANNELS*WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   in_mode         0 = pass beat sum, 1 = accumulate
//   in_clear        clear acc, count and overflow before applying this beat
//   out_valid       out_sum holds a result
//   out_ready       consumer accepts the result
//   out_sum         result (ACC_WIDTH bits)
//   sample_count    beats applied since reset or the last clear
//   overflow        sticky: accumulator wrapped or saturated
//
// ACC_WIDTH must be at least WIDTH + clog2(CHANNELS) so a beat sum never
// carries out of the accumulator width on its own.

module multi_channel_accumulator #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int ACC_WIDTH = 32,
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_mode,
  input  logic                      in_clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_sum,
  output logic [CNT_WIDTH-1:0]      sample_count,
  output logic                      overflow
);

  // Stage 1 registers
  logic                 s1_valid;
  logic [ACC_WIDTH-1:0] s1_sum;
  logic                 s1_mode;
  logic                 s1_clear;

  // Running total, separate from out_sum because pass-mode beats must not
  // disturb it.
  logic [ACC_WIDTH-1:0] acc;

  logic                 in_fire;
  logic                 s1_advance;
  logic [ACC_WIDTH-1:0] beat_sum;

  logic [ACC_WIDTH-1:0] acc_base;
  logic [ACC_WIDTH:0]   acc_ext;
  logic                 acc_carry;
  logic [ACC_WIDTH-1:0] acc_res;

  // S2 can take S1's beat when it is empty or being drained this cycle.
  assign s1_advance = s1_valid & (~out_valid | out_ready);
  assign in_ready   = ~rst & (~s1_valid | s1_advance);
  assign in_fire    = in_valid & in_ready;

  // Channel adder, zero-extended to the accumulator width.
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      beat_sum = beat_sum + ACC_WIDTH'(in_data[k*WIDTH +: WIDTH]);
    end
  end

  // Accumulate path: one extra bit captures the carry that flags overflow.
  always_comb begin
    acc_base  = s1_clear ? '0 : acc;
    acc_ext   = {1'b0, acc_base} + {1'b0, s1_sum};
    acc_carry = acc_ext[ACC_WIDTH];
    if (acc_carry && (SATURATE != 0)) begin
      acc_res = '1;
    end else begin
      acc_res = acc_ext[ACC_WIDTH-1:0];
    end
  end

  // Stage 1
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mode  <= 1'b0;
      s1_clear <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sum   <= beat_sum;
        s1_mode  <= in_mode;
        s1_clear <= in_clear;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 / output stage. Every output register only changes on an
  // advance, which keeps them stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      acc          <= '0;
      sample_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (s1_advance) begin
        out_valid <= 1'b1;

        if (s1_clear) begin
          sample_count <= CNT_WIDTH'(1);
        end else begin
          sample_count <= sample_count + CNT_WIDTH'(1);
        end

        if (s1_mode) begin
          acc     <= acc_res;
          out_sum <= acc_res;
          // Clear wipes the old flag; a carry on this same beat sets it.
          overflow <= (overflow & ~s1_clear) | acc_carry;
        end else begin
          out_sum <= s1_sum;
          if (s1_clear) begin
            acc      <= '0;
            overflow <= 1'b0;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Testbench for multi_channel_accumulator.
// Three instances share one stimulus stream: 32-bit wrap, 10-bit wrap and
// 10-bit saturate, so overflow behaviour of both flavours is observed on the
// same beats.

module tb_multi_channel_accumulator;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_mode;
  logic        in_clear;
  logic        out_ready;

  logic        ready_a, valid_a, ovf_a;
  logic [31:0] sum_a;
  logic [15:0] cnt_a;
  logic        ready_w, valid_w, ovf_w;
  logic [9:0]  sum_w;
  logic [15:0] cnt_w;
  logic        ready_s, valid_s, ovf_s;
  logic [9:0]  sum_s;
  logic [15:0] cnt_s;

  int checks;
  int errors;
  int n_out;

  multi_channel_accumulator #(
    .WIDTH(8), .CHANNELS(4), .ACC_WIDTH(32), .SATURATE(0), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(in_data), .in_mode(in_mode), .in_clear(in_clear),
    .out_valid(valid_a), .out_ready(out_ready), .out_sum(sum_a),
    .sample_count(cnt_a), .overflow(ovf_a)
  );

  multi_channel_accumulator #(
    .WIDTH(8), .CHANNELS(4), .ACC_WIDTH(10), .SATURATE(0), .CNT_WIDTH(16)
  ) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_w),
    .in_data(in_data), .in_mode(in_mode), .in_clear(in_clear),
    .out_valid(valid_w), .out_ready(out_ready), .out_sum(sum_w),
    .sample_count(cnt_w), .overflow(ovf_w)
  );

  multi_channel_accumulator #(
    .WIDTH(8), .CHANNELS(4), .ACC_WIDTH(10), .SATURATE(1), .CNT_WIDTH(16)
  ) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_s),
    .in_data(in_data), .in_mode(in_mode), .in_clear(in_clear),
    .out_valid(valid_s), .out_ready(out_ready), .out_sum(sum_s),
    .sample_count(cnt_s), .overflow(ovf_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-instance state: 0 = 32-bit wrap, 1 = 10-bit wrap, 2 = 10-bit saturate.
  longint unsigned m_acc[3];
  int unsigned     m_cnt[3];
  bit              m_ovf[3];

  logic [63:0] exp_a_q[$];
  logic [63:0] exp_w_q[$];
  logic [63:0] exp_s_q[$];

  function automatic logic [63:0] pack(input logic o, input logic [15:0] c, input logic [31:0] s);
    return {15'd0, o, c, s};
  endfunction

  function automatic int unsigned beat_total(input logic [31:0] d);
    int unsigned t;
    t = 0;
    for (int k = 0; k < 4; k++) t += d[k*8 +: 8];
    return t;
  endfunction

  function automatic logic [63:0] model_step(input int id, input int unsigned bsum,
                                             input bit mode, input bit clr);
    longint unsigned limit, total;
    logic [63:0] res;
    logic [31:0] cnt16;
    limit = (id == 0) ? 64'd4294967296 : 64'd1024;
    if (clr) begin
      m_cnt[id] = 0;
      m_ovf[id] = 1'b0;
    end
    m_cnt[id] = (m_cnt[id] + 1) % 65536;
    if (mode) begin
      total = (clr ? 64'd0 : m_acc[id]) + bsum;
      if (total >= limit) begin
        m_ovf[id] = 1'b1;
        total = (id == 2) ? limit - 1 : total - limit;
      end
      m_acc[id] = total;
      res = total;
    end else begin
      if (clr) m_acc[id] = 0;
      res = bsum;
    end
    cnt16 = m_cnt[id];
    return pack(m_ovf[id], cnt16[15:0], res[31:0]);
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_a_q.delete();
      exp_w_q.delete();
      exp_s_q.delete();
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = 0;
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end
    end else begin
      if (valid_a && out_ready) begin
        n_out++;
        if (exp_a_q.size() == 0 || exp_w_q.size() == 0 || exp_s_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_spurious: output sum 0x%0h with no expected entry (required none)", sum_a);
        end else begin
          chk("sb_a", pack(ovf_a, cnt_a, sum_a), exp_a_q.pop_front());
          chk("sb_w", pack(ovf_w, cnt_w, {22'd0, sum_w}), exp_w_q.pop_front());
          chk("sb_s", pack(ovf_s, cnt_s, {22'd0, sum_s}), exp_s_q.pop_front());
        end
      end
      if (in_valid && ready_a) begin
        exp_a_q.push_back(model_step(0, beat_total(in_data), in_mode, in_clear));
        exp_w_q.push_back(model_step(1, beat_total(in_data), in_mode, in_clear));
        exp_s_q.push_back(model_step(2, beat_total(in_data), in_mode, in_clear));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+#1 with out_ready=1 and the pipeline idle. Returns at the
  // negedge after which the result must be visible (2 edges after accept).
  task automatic one_beat(input logic [31:0] d, input logic m, input logic c, input string tag);
    int waited;
    in_data  = d;
    in_mode  = m;
    in_clear = c;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!ready_a && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_accept"}, ready_a, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, valid_a, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, valid_a, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic        mode;
    logic        clear;
    logic [31:0] sum_a;
    logic [31:0] sum_w;
    logic [31:0] sum_s;
    logic [15:0] cnt;
    logic [2:0]  ovf;   // {a, w, s}
  } vec_t;

  vec_t tbl[12];

  initial begin
    int sent;
    int outs_before;
    bit took;

    tbl[0]  = '{32'h04030201, 1'b0, 1'b0,   10,  10,   10, 16'd1, 3'b000};
    tbl[1]  = '{32'h01010101, 1'b1, 1'b1,    4,   4,    4, 16'd1, 3'b000};
    tbl[2]  = '{32'h02020202, 1'b1, 1'b0,   12,  12,   12, 16'd2, 3'b000};
    tbl[3]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 1032,   8, 1023, 16'd3, 3'b011};
    tbl[4]  = '{32'h00000001, 1'b1, 1'b1,    1,   1,    1, 16'd1, 3'b000};
    tbl[5]  = '{32'h00000009, 1'b0, 1'b0,    9,   9,    9, 16'd2, 3'b000};
    tbl[6]  = '{32'h00000002, 1'b1, 1'b0,    3,   3,    3, 16'd3, 3'b000};
    tbl[7]  = '{32'hFFFFFFFF, 1'b1, 1'b1, 1020, 1020, 1020, 16'd1, 3'b000};
    tbl[8]  = '{32'h02020202, 1'b1, 1'b0, 1028,   4, 1023, 16'd2, 3'b011};
    tbl[9]  = '{32'h00000005, 1'b0, 1'b0,    5,   5,    5, 16'd3, 3'b011};
    tbl[10] = '{32'h00000000, 1'b0, 1'b1,    0,   0,    0, 16'd1, 3'b000};
    tbl[11] = '{32'h07000000, 1'b1, 1'b0,    7,   7,    7, 16'd2, 3'b000};

    checks    = 0;
    errors    = 0;
    n_out     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_clear  = 1'b0;
    out_ready = 1'b1;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ready_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", valid_a, 0);
    chk("rst_out_sum", sum_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_overflow", {ovf_a, ovf_w, ovf_s}, 0);
    chk("rst_in_ready_after", {ready_a, ready_w, ready_s}, 3'b111);
    @(posedge clk);
    #1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 12; i++) begin
      one_beat(tbl[i].data, tbl[i].mode, tbl[i].clear, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_sum_a", i), sum_a, tbl[i].sum_a);
      chk($sformatf("vec%0d_sum_w", i), sum_w, tbl[i].sum_w);
      chk($sformatf("vec%0d_sum_s", i), sum_s, tbl[i].sum_s);
      chk($sformatf("vec%0d_count", i), cnt_a, tbl[i].cnt);
      chk($sformatf("vec%0d_ovf", i), {ovf_a, ovf_w, ovf_s}, tbl[i].ovf);
      @(posedge clk);
      #1;
    end

    // ---- backpressure: 5 beats, consumer stalled for 4 cycles ----
    out_ready   = 1'b0;
    sent        = 0;
    outs_before = n_out;
    for (int cyc = 0; cyc < 40 && (sent < 5 || n_out - outs_before < 5); cyc++) begin
      if (cyc == 4) out_ready = 1'b1;
      in_valid = (sent < 5);
      in_data  = 32'(10 * (sent + 1));
      in_mode  = 1'b1;
      in_clear = (sent == 0);
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        chk($sformatf("bp_ready_low_c%0d", cyc), ready_a, 0);
        chk($sformatf("bp_hold_valid_c%0d", cyc), valid_a, 1);
        chk($sformatf("bp_hold_sum_c%0d", cyc), sum_a, 10);
        chk($sformatf("bp_hold_count_c%0d", cyc), cnt_a, 1);
      end
      if (cyc == 4) chk("bp_ready_release", ready_a, 1);
      if (in_valid && ready_a) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", sent, 5);
    chk("bp_outputs", n_out - outs_before, 5);

    // ---- reset mid-stream with two beats in flight ----
    out_ready = 1'b1;
    in_mode   = 1'b1;
    in_data   = 32'hFFFFFFFF;
    in_valid  = 1'b1;
    in_clear  = 1'b1;
    @(posedge clk);
    #1 in_clear = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid_before", valid_a, 1);
    chk("rstmid_ovf_w_before", ovf_w, 1);
    chk("rstmid_ready_in_rst", ready_a, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", valid_a, 0);
    chk("rstmid_count", cnt_a, 0);
    chk("rstmid_ovf", {ovf_a, ovf_w, ovf_s}, 0);
    chk("rstmid_ready", ready_a, 1);
    @(posedge clk);
    #1;
    one_beat(32'h00000005, 1'b1, 1'b0, "rstmid_next");
    chk("rstmid_next_sum_a", sum_a, 5);
    chk("rstmid_next_sum_s", sum_s, 5);
    chk("rstmid_next_count", cnt_a, 1);
    @(posedge clk);
    #1;

    // ---- randomized traffic against the model ----
    took = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!in_valid || took || rst) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_data  = $urandom();
        in_mode  = 1'($urandom_range(0, 1));
        in_clear = ($urandom_range(0, 7) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      took = in_valid && ready_a;
      @(posedge clk);
      #1;
    end

    // ---- drain ----
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty_a", exp_a_q.size(), 0);
    chk("drain_empty_w", exp_w_q.size(), 0);
    chk("drain_empty_s", exp_s_q.size(), 0);
    chk("drain_idle", valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_accumulator.md
# multi_channel_accumulator

Parametrised, pipelined N-channel summing accumulator with valid/ready handshakes on input and output. Each accepted input beat carries CHANNELS unsigned words. The block adds the words together, then either passes the sum straight through or adds it to a running total. It also counts accepted samples and keeps a sticky overflow flag. It sits between sample producers and any consumer that needs per-beat sums or running totals, and replaces ad-hoc `a + b + c + d` registers with one reusable block.

## Interface
- WIDTH, 8, width of each channel word (unsigned)
- CHANNELS, 4, number of channel words per beat (≥1)
- ACC_WIDTH, 32, width of the accumulator and output; must be ≥ WIDTH + clog2(CHANNELS)
- SATURATE, 0, 0 = accumulator wraps on overflow; 1 = accumulator clamps to all-ones
- CNT_WIDTH, 16, width of the sample counter

Ports:
- clk  in  1  clock; all logic updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  an input beat is present
- in_ready  out  1  block can accept a beat; held 0 while rst=1
- in_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_mode  in  1  0 = pass (per-beat sum), 1 = accumulate; sampled with the beat
- in_clear  in  1  clear the accumulator before this beat is applied; sampled with the beat
- out_valid  out  1  out_sum holds a result
- out_ready  in  1  consumer accepts the result
- out_sum  out  ACC_WIDTH  result
- sample_count  out  CNT_WIDTH  number of beats applied since reset or the last clear
- overflow  out  1  sticky; accumulator has wrapped or saturated

## Operation
- A transfer occurs on a cycle where the handshake signals are both 1: in_valid & in_ready on the input side, out_valid & out_ready on the output side.
- Stage 1 (S1): on an input transfer, register the channel sum, zero-extended to ACC_WIDTH, together with the beat's mode and clear bits. Set s1_valid.
- Stage 2 (S2, output stage): S1 advances into S2 when s1_valid & (!out_valid | out_ready). On advance:
  - Mode 0: out_sum = channel sum. The accumulator register is unchanged.
  - Mode 1: base = clear ? 0 : acc. The next value is base + channel sum, computed at ACC_WIDTH+1 bits.
    - If the carry bit is 1: set overflow. With SATURATE=1, the result is all-ones; otherwise the result is truncated to ACC_WIDTH.
    - acc and out_sum both take the result.
  - Clear (either mode): sample_count and overflow are cleared, then this beat is counted, so sample_count = 1 afterwards.
  - Without clear: sample_count increments and wraps at 2^CNT_WIDTH.
  - In mode 0 with clear: acc is set to 0.
- in_ready = !rst & (!s1_valid | S1 advances this cycle). This gives full throughput of one beat per cycle with no bubbles.
- out_valid is set on an S1 advance. It clears on an output transfer that has no simultaneous advance.
- out_sum, sample_count and overflow stay stable while out_valid=1 and out_ready=0.
- Mode and clear may change on every beat. Each beat is processed with its own mode and clear bits.

## Timing
- Reset values: in_ready=0 during rst, 1 on the first cycle after rst falls. out_valid=0, out_sum=0, sample_count=0, overflow=0, acc=0, s1_valid=0.
- Latency: 2 cycles. A beat accepted at edge n appears with out_valid=1 after edge n+1, assuming no backpressure.
- Backpressure: with out_ready=0, the block accepts 2 beats (S1 and S2 full), then in_ready=0. in_ready returns combinationally on the cycle out_ready=1.
- Reset mid-operation: all in-flight beats are discarded, and all registers take their reset values at that edge.
- Simultaneous output transfer and S1 advance: out_valid stays 1 and the new result replaces the old one at that edge.
- Adder: CHANNELS-input unsigned sum, purely combinational in front of S1. Beat-sum width is WIDTH+clog2(CHANNELS).

## Test plan
- Pass mode, W=8, C=4: beat {1,2,3,4} with out_ready=1 → out_valid 2 cycles later, out_sum=10, sample_count=1.
- Accumulate: beats {1,1,1,1}, {2,2,2,2}, {255,255,255,255}, mode=1, clear on the first beat → out_sum 4, 12, 1032; sample_count 1, 2, 3; overflow=0.
- Overflow, ACC_WIDTH=10:
  - SATURATE=0, beats 1020 then 8 → out_sum 1020, then 4, with overflow=1.
  - SATURATE=1, same beats → 1020, then 1023, with overflow=1.
  - A later beat with clear → overflow=0.
- Backpressure: stream 5 beats continuously with out_ready=0 for 4 cycles → in_ready falls after 2 accepts. On release, all 5 results appear in order with no loss or duplication, and out_sum is stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight → the next cycle shows out_valid=0, sample_count=0, overflow=0, and in_ready=1 after rst falls. A following mode=1 beat {5,0,0,0} without clear → out_sum=5.
- Mode interleave: beats mode 1 {1,0,0,0}, mode 0 {9,0,0,0}, mode 1 {2,0,0,0} → out_sum 1, 9, 3. The accumulator is unaffected by the mode-0 beat.
